// File: rtl/vsn_route_ctrl.sv
// VSN cable-plant routing controller.
// Shadow/active route tables, commits only at packet boundaries.
module vsn_route_ctrl #(
  parameter int NPORTS  = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11,
  parameter int GEN_W   = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [IDX_W-1:0]        cfg_dst,
  input  logic [IDX_W-1:0]        cfg_src,
  input  logic                    cfg_en,
  input  logic                    commit_valid,
  output logic                    commit_ready,
  input  logic [NPORTS-1:0]       dac_tvalid,
  input  logic [NPORTS-1:0]       dac_tready,
  input  logic [NPORTS-1:0]       dac_tlast,
  output logic [NPORTS*IDX_W-1:0] route_sel,
  output logic [NPORTS-1:0]       route_en,
  output logic                    busy,
  output logic                    commit_done,
  output logic                    commit_err,
  output logic [GEN_W-1:0]        route_gen
);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t                         r_state;
  logic [NPORTS-1:0][IDX_W-1:0]   r_sh_sel;
  logic [NPORTS-1:0]              r_sh_en;
  logic [NPORTS-1:0][IDX_W-1:0]   r_act_sel;
  logic [NPORTS-1:0]              r_act_en;
  logic [NPORTS-1:0]              r_in_pkt;
  logic [CNT_W-1:0]               r_cnt;
  logic [GEN_W-1:0]               r_gen;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_err;

  logic [NPORTS-1:0]              w_hs;
  logic [NPORTS-1:0]              w_nxt;
  logic [NPORTS-1:0]              w_req;
  logic                           w_quiet;
  logic                           w_cfg_wr;
  logic                           w_dst_ok;

  assign w_hs      = dac_tvalid & dac_tready;
  assign w_nxt     = (w_hs & ~dac_tlast) | (~w_hs & r_in_pkt);
  assign w_quiet   = ~|(w_req & w_nxt);
  assign cfg_ready = (r_state == S_IDLE);
  assign w_cfg_wr  = cfg_valid & cfg_ready;
  assign w_dst_ok  = ({1'b0, cfg_dst} < (IDX_W+1)'(NPORTS));

  assign commit_ready = (r_state == S_IDLE);
  assign route_sel    = r_act_sel;
  assign route_en     = r_act_en;
  assign busy         = r_busy;
  assign commit_done  = r_done;
  assign commit_err   = r_err;
  assign route_gen    = r_gen;

  // Sources feeding a changed destination, old or new side.
  always_comb begin
    w_req = '0;
    for (int d = 0; d < NPORTS; d++) begin
      if ({r_sh_sel[d], r_sh_en[d]} != {r_act_sel[d], r_act_en[d]}) begin
        if (r_act_en[d]) w_req[r_act_sel[d]] = 1'b1;
        if (r_sh_en[d])  w_req[r_sh_sel[d]]  = 1'b1;
      end
    end
  end

  // Per-source packet tracking, runs in every state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_in_pkt <= '0;
    else          r_in_pkt <= w_nxt;
  end

  // Shadow table writes, only while idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sh_sel <= '0;
      r_sh_en  <= '0;
    end else if (w_cfg_wr && w_dst_ok) begin
      r_sh_sel[cfg_dst] <= cfg_src;
      r_sh_en[cfg_dst]  <= cfg_en;
    end
  end

  // Commit FSM: drain until quiesced, then swap or time out.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_act_sel <= '0;
      r_act_en  <= '0;
      r_cnt     <= '0;
      r_gen     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (commit_valid) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_quiet) begin
            r_act_sel <= r_sh_sel;
            r_act_en  <= r_sh_en;
            r_gen     <= r_gen + 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vsn_route_ctrl.md
Name: vsn_route_ctrl

Overview:
- Routing controller for the VSN cable plant. Holds a shadow and an active route table mapping each ADC-side destination to a DAC-side source.
- Commits shadow to active only when every affected stream is at a packet boundary. No packet is ever split across two routes.
- Sits beside the cable-plant crossbar. Observes DAC-side AXI4-Stream handshakes and drives the crossbar's select/enable lines.

Parameters:
NPORTS, 8, number of DAC sources and ADC destinations
IDX_W, 3, index width, clog2(NPORTS)
TIMEOUT, 1024, max DRAIN cycles before commit aborts
CNT_W, 11, timeout counter width, must hold TIMEOUT
GEN_W, 8, commit generation counter width

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
cfg_valid  in  1  shadow-table write request
cfg_ready  out  1  write accepted when high with cfg_valid
cfg_dst  in  IDX_W  destination index
cfg_src  in  IDX_W  source index
cfg_en  in  1  destination enable
commit_valid  in  1  commit request
commit_ready  out  1  high in IDLE
dac_tvalid  in  NPORTS  per-source tvalid (monitor only)
dac_tready  in  NPORTS  per-source tready (monitor only)
dac_tlast  in  NPORTS  per-source tlast (monitor only)
route_sel  out  NPORTS*IDX_W  active source per destination; dst d at [d*IDX_W +: IDX_W]
route_en  out  NPORTS  active enable per destination
busy  out  1  high in DRAIN
commit_done  out  1  one-cycle pulse, commit applied
commit_err  out  1  one-cycle pulse, commit aborted on timeout
route_gen  out  GEN_W  count of successful commits, wraps

Behaviour:
- Everything is registered. Asynchronous clear on aresetn=0 sets all of the following:
  - shadow and active sel = 0, en = 0;
  - in_pkt = 0, state = IDLE;
  - route_gen = 0, busy = 0, commit_done = 0, commit_err = 0.
- Reset during DRAIN drops the pending commit.
- Packet tracking, per source s:
  - hs[s] = tvalid & tready.
  - nxt[s] = hs ? ~tlast : in_pkt[s].
  - in_pkt[s] <= nxt[s] every cycle, in any state.
- Shadow writes:
  - cfg_ready = (state==IDLE).
  - On cfg_valid & cfg_ready: shadow[cfg_dst] <= {cfg_src, cfg_en}.
  - Writes with cfg_dst >= NPORTS are accepted and ignored.
- Fan-out is legal: one source may feed several destinations.
- Changed set: destination d is changed when shadow[d] != active[d], comparing {sel, en}.
- Required sources are, for each changed d:
  - active sel if active en = 1;
  - shadow sel if shadow en = 1.
- Quiesced = nxt[s]==0 for every required source s. An empty changed set is trivially quiesced.
- State machine:
  - IDLE: commit_ready = 1. On commit_valid, go to DRAIN and clear the timeout counter.
  - A cfg write and a commit in the same cycle are both taken; that write is part of the commit.
  - DRAIN: busy = 1 and cfg_ready = 0. Each cycle:
    - if quiesced: active <= shadow, route_gen <= route_gen+1, pulse commit_done, go to IDLE;
    - else if counter == TIMEOUT-1: active unchanged, shadow kept, pulse commit_err, go to IDLE;
    - else counter++.
  - Quiesced has priority over timeout in the same cycle.
- Latency: commit accepted at cycle T gives DRAIN at T+1. The earliest new route_sel/route_en and commit_done appear at T+2.
- A beat in the cycle the update lands uses the old route. Quiesced guarantees that beat is a tlast or idle, so no packet is split.
- Only changed destinations switch. Unchanged destinations keep routing through DRAIN with no glitch.
- Outputs change only in the commit cycle.
- route_gen wraps from 2^GEN_W-1 to 0.

Test Plan:
- Reset, then write dst2←src5 en=1 and commit, all sources idle -> route_sel[2]=5, route_en[2]=1 at T+2; commit_done one pulse; route_gen=1.
- Src5 mid-packet (non-last beat seen); change dst2 to src1 and commit -> busy held, route_sel[2] stays 5 until src5's tlast beat cycle C; route_sel[2]=1 at C+1; commit_done at C+1.
- Required source stays mid-packet with TIMEOUT=16 -> commit_err pulse 16 cycles after DRAIN entry; routes unchanged; route_gen unchanged; cfg_ready back to 1.
- cfg_valid and commit_valid in the same IDLE cycle (dst0←src3) -> commit includes dst0; cfg_valid during DRAIN -> cfg_ready=0 and shadow unchanged.
- Commit with shadow equal to active -> commit_done at T+2, route_gen increments, no output change; 256 commits with GEN_W=8 -> route_gen wraps to 0.
- aresetn low mid-DRAIN -> immediate IDLE, route_en=0, busy=0, no done or err pulse after reset release.
